hack_cpu_ctrl: RTL and testbench

Multi-cycle control sequencer for the Hack CPU: it fetches 16-bit instructions from instruction ROM, decodes them, and drives the six ALU control bits and operands. It owns the A, D and PC registers, handles data-memory reads and writes over a req/ack handshake, and evaluates jump conditions from the ALU's zr/ng flags. It sits between instruction ROM, data RAM and the combinational ALU, which remains a separate instance.

---
 rtl/hack_pkg.sv | 37 +++
 rtl/hack_cpu_ctrl_if.sv | 64 ++++++
 rtl/hack_jump_cond.sv | 21 ++
 rtl/hack_cpu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hack_pkg
//  Brief    : Shared types and constants for the Hack CPU control sequencer:
//             state encoding, instruction field positions and bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;

    // Instruction field positions
    localparam int IS_C    = 15;
    localparam int ABIT    = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    // Individual destination bits inside DEST
    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        EXEC   = 3'd3,
        MEMWR  = 3'd4
    } state_t;

endpackage : hack_pkg
`default_nettype wire

// File: rtl/hack_cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hack_cpu_ctrl_if
//  Brief    : Bundles the instruction-ROM, ALU, data-memory and debug signals
//             of the Hack control sequencer. master = sequencer side,
//             slave = ROM / ALU / RAM environment side.
//  Revision : 1.0 - initial release
// ============================================================================
interface hack_cpu_ctrl_if;
    import hack_pkg::*;

    // Instruction ROM
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;

    // Combinational ALU
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zx;
    logic              alu_nx;
    logic              alu_zy;
    logic              alu_ny;
    logic              alu_f;
    logic              alu_no;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;

    // Data memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Architectural state for debug
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;

    modport master (
        output rom_addr, rom_en,
        input  rom_data,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output pc, a_reg, d_reg
    );

    modport slave (
        input  rom_addr, rom_en,
        output rom_data,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  pc, a_reg, d_reg
    );

endinterface : hack_cpu_ctrl_if
`default_nettype wire

// File: rtl/hack_jump_cond.sv
`default_nettype none
// ============================================================================
//  Module   : hack_jump_cond
//  Brief    : Hack jump-condition evaluator. j[2]=less-than, j[1]=equal,
//             j[0]=greater-than, tested against the ALU zr/ng flags.
//  Revision : 1.0 - initial release
// ============================================================================
module hack_jump_cond (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       jump
);

    // Any selected relation that holds for the ALU result takes the jump
    always_comb begin
        jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    end

endmodule : hack_jump_cond
`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hack_cpu_ctrl
//  Brief    : Multi-cycle Hack CPU control sequencer. Fetches and decodes
//             instructions, owns A/D/PC, drives the external ALU and performs
//             data-memory reads/writes over a req/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl (
    input  logic            clk,
    input  logic            reset,
    hack_cpu_ctrl_if.master bus
);
    import hack_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mreg;
    logic [DATA_W-1:0] r_wreg;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_tgt;
    logic              r_jump;

    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_jump;
    logic              w_ack;

    logic              w_rom_en;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [5:0]        w_alu_ctrl;

    // Opcode marker and the two ignored bits of a C-instruction carry no
    // information once the instruction has been dispatched.
    logic              w_unused_ir;
    assign w_unused_ir = ^r_ir[IS_C:13];

    // Wraps naturally from 0x7FFF to 0x0000 at 15 bits
    assign w_pc_inc = r_pc + 15'd1;

    // An acknowledge only counts while a request is actually being presented
    assign w_ack = w_mem_req & bus.mem_ack;

    hack_jump_cond u_jump_cond (
        .j    (r_ir[JMP_HI:JMP_LO]),
        .zr   (bus.alu_zr),
        .ng   (bus.alu_ng),
        .jump (w_jump)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state bus/ALU outputs; strobes are held low in reset
    always_comb begin
        w_state_nxt = r_state;
        w_rom_en    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_alu_ctrl  = 6'b000000;
        case (r_state)
            FETCH: begin
                w_rom_en    = ~reset;
                w_state_nxt = DECODE;
            end
            DECODE: begin
                if (!bus.rom_data[IS_C]) begin
                    w_state_nxt = FETCH;
                end else if (bus.rom_data[ABIT]) begin
                    w_state_nxt = MEMRD;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            MEMRD: begin
                w_mem_req  = ~reset;
                w_mem_addr = r_a[ADDR_W-1:0];
                if (bus.mem_ack && !reset) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_alu_ctrl  = r_ir[CTRL_HI:CTRL_LO];
                w_state_nxt = r_ir[DEST_M] ? MEMWR : FETCH;
            end
            MEMWR: begin
                w_mem_req   = ~reset;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_waddr;
                w_mem_wdata = r_wreg;
                if (bus.mem_ack && !reset) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // Architectural registers and transfer holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
            r_mreg  <= '0;
            r_wreg  <= '0;
            r_pc    <= '0;
            r_waddr <= '0;
            r_tgt   <= '0;
            r_jump  <= 1'b0;
        end else begin
            case (r_state)
                DECODE: begin
                    r_ir <= bus.rom_data;
                    if (!bus.rom_data[IS_C]) begin
                        r_a  <= {1'b0, bus.rom_data[ADDR_W-1:0]};
                        r_pc <= w_pc_inc;
                    end
                end
                MEMRD: begin
                    if (w_ack) begin
                        r_mreg <= bus.mem_rdata;
                    end
                end
                EXEC: begin
                    // M target and jump target both use A from before this
                    // instruction, even when A is also a destination.
                    r_wreg  <= bus.alu_out;
                    r_waddr <= r_a[ADDR_W-1:0];
                    r_tgt   <= r_a[ADDR_W-1:0];
                    if (r_ir[DEST_A]) begin
                        r_a <= bus.alu_out;
                    end
                    if (r_ir[DEST_D]) begin
                        r_d <= bus.alu_out;
                    end
                    if (r_ir[DEST_M]) begin
                        r_jump <= w_jump;
                    end else begin
                        r_pc <= w_jump ? r_a[ADDR_W-1:0] : w_pc_inc;
                    end
                end
                MEMWR: begin
                    if (w_ack) begin
                        r_pc <= r_jump ? r_tgt : w_pc_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        bus.rom_addr  = reset ? '0 : r_pc;
        bus.rom_en    = w_rom_en;
        bus.alu_x     = r_d;
        bus.alu_y     = r_ir[ABIT] ? r_mreg : r_a;
        bus.alu_zx    = w_alu_ctrl[5];
        bus.alu_nx    = w_alu_ctrl[4];
        bus.alu_zy    = w_alu_ctrl[3];
        bus.alu_ny    = w_alu_ctrl[2];
        bus.alu_f     = w_alu_ctrl[1];
        bus.alu_no    = w_alu_ctrl[0];
        bus.mem_req   = w_mem_req;
        bus.mem_we    = w_mem_we;
        bus.mem_addr  = w_mem_addr;
        bus.mem_wdata = w_mem_wdata;
        bus.pc        = r_pc;
        bus.a_reg     = r_a;
        bus.d_reg     = r_d;
    end

endmodule : hack_cpu_ctrl
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_cpu_ctrl
//  Brief    : Directed self-checking bench for hack_cpu_ctrl with a ROM image,
//             a Hack ALU model and a RAM with programmable ack latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_ctrl;

    logic clk;
    logic reset;

    hack_cpu_ctrl_if bus ();

    hack_cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] rom [0:31];
    logic [15:0] ram [0:127];
    logic [15:0] rom_q;
    int          ack_delay;
    int          wait_cnt;
    int          n_writes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rom_en) rom_q <= rom[bus.rom_addr[4:0]];
    end
    assign bus.rom_data = rom_q;

    // Hack ALU reference model
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_zx ? 16'h0000 : bus.alu_x;
        if (bus.alu_nx) ax = ~ax;
        ay = bus.alu_zy ? 16'h0000 : bus.alu_y;
        if (bus.alu_ny) ay = ~ay;
        ao = bus.alu_f ? (ax + ay) : (ax & ay);
        if (bus.alu_no) ao = ~ao;
    end
    assign bus.alu_out = ao;
    assign bus.alu_zr  = (ao == 16'h0000);
    assign bus.alu_ng  = ao[15];

    // RAM with ack after ack_delay waiting cycles
    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = ram[bus.mem_addr[6:0]];
    always @(posedge clk) begin
        if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                                      wait_cnt <= wait_cnt + 1;
        if (!reset && bus.mem_req && bus.mem_ack && bus.mem_we) begin
            ram[bus.mem_addr[6:0]] <= bus.mem_wdata;
            n_writes <= n_writes + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the FETCH of a given pc
    task automatic wait_fetch(input logic [14:0] target, input int budget);
        int n = 0;
        while (!(bus.rom_en === 1'b1 && bus.pc === target) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_fetch_pc", {16'h0, bus.rom_en, bus.pc}, {16'h0, 1'b1, target});
    endtask

    initial begin
        for (int i = 0; i < 32; i++)  rom[i] = 16'h0000;
        for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
        ram[3]   = 16'h0007;
        rom[0]  = 16'h0005;  // @5
        rom[1]  = 16'hEC10;  // D=A
        rom[2]  = 16'h0003;  // @3
        rom[3]  = 16'hF090;  // D=D+M
        rom[4]  = 16'h0064;  // @100
        rom[5]  = 16'h1234;  // @0x1234
        rom[6]  = 16'hEC10;  // D=A
        rom[7]  = 16'h0064;  // @100
        rom[8]  = 16'hE308;  // M=D
        rom[9]  = 16'h0001;  // @1
        rom[10] = 16'hEC10;  // D=A
        rom[11] = 16'h000E;  // @14
        rom[12] = 16'hE301;  // D;JGT (taken)
        rom[13] = 16'hEA90;  // skipped
        rom[14] = 16'hEA90;  // D=0
        rom[15] = 16'h0014;  // @20
        rom[16] = 16'hE301;  // D;JGT (D=0, not taken)
        rom[17] = 16'h4000;  // @0x4000
        rom[18] = 16'hEC10;  // D=A
        rom[19] = 16'hE090;  // D=D+A -> 0x8000
        rom[20] = 16'h001E;  // @30
        rom[21] = 16'hE301;  // D;JGT (negative, not taken)
        rom[22] = 16'hE308;  // M=D, interrupted by reset
        rom_q     = 16'h0000;
        ack_delay = 0;
        wait_cnt  = 0;
        n_writes  = 0;

        // Reset for two cycles
        reset = 1'b1;
        tick();
        chk("rst_rom_en", {31'h0, bus.rom_en}, 32'h0);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_rom_en", {31'h0, bus.rom_en}, 32'h1);
        chk("rel_pc", {17'h0, bus.pc}, 32'h0);
        chk("rel_a", {16'h0, bus.a_reg}, 32'h0);
        chk("rel_d", {16'h0, bus.d_reg}, 32'h0);
        chk("rel_mem_req", {31'h0, bus.mem_req}, 32'h0);

        // @5 ; D=A : EXEC is the fifth cycle, next FETCH the sixth
        repeat (4) tick();
        chk("da_ctrl", {26'h0, bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}, 32'h30);
        chk("da_alu_y", {16'h0, bus.alu_y}, 32'h5);
        chk("da_a", {16'h0, bus.a_reg}, 32'h5);
        tick();
        chk("da_d", {16'h0, bus.d_reg}, 32'h5);
        chk("da_pc", {17'h0, bus.pc}, 32'h2);
        chk("da_rom_en", {31'h0, bus.rom_en}, 32'h1);

        // @3 ; D=D+M with two wait cycles on the read
        ack_delay = 2;
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            chk("rd_req", {31'h0, bus.mem_req}, 32'h1);
            chk("rd_addr_we", {16'h0, bus.mem_we, bus.mem_addr}, {16'h0, 1'b0, 15'd3});
            chk("rd_ack", {31'h0, bus.mem_ack}, (k == 2) ? 32'h1 : 32'h0);
            tick();
        end
        chk("rd_exec_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rd_alu_y", {16'h0, bus.alu_y}, 32'h7);
        chk("rd_alu_x", {16'h0, bus.alu_x}, 32'h5);
        tick();
        chk("rd_d", {16'h0, bus.d_reg}, 32'hC);
        chk("rd_pc", {17'h0, bus.pc}, 32'h4);

        // M=D with same-cycle ack
        ack_delay = 0;
        wait_fetch(15'd8, 40);
        repeat (3) tick();
        chk("wr_req", {31'h0, bus.mem_req}, 32'h1);
        chk("wr_we", {31'h0, bus.mem_we}, 32'h1);
        chk("wr_addr", {17'h0, bus.mem_addr}, 32'd100);
        chk("wr_wdata", {16'h0, bus.mem_wdata}, 32'h1234);
        tick();
        chk("wr_done_req", {31'h0, bus.mem_req}, 32'h0);
        chk("wr_pc", {17'h0, bus.pc}, 32'd9);
        chk("wr_a", {16'h0, bus.a_reg}, 32'd100);
        chk("wr_ram", {16'h0, ram[100]}, 32'h1234);
        chk("wr_count", n_writes, 32'd1);

        // JGT taken with D=1
        wait_fetch(15'd12, 20);
        chk("j1_d", {16'h0, bus.d_reg}, 32'h1);
        repeat (3) tick();
        chk("j1_pc", {17'h0, bus.pc}, 32'd14);

        // JGT not taken with D=0
        wait_fetch(15'd16, 20);
        chk("j0_d", {16'h0, bus.d_reg}, 32'h0);
        repeat (3) tick();
        chk("j0_pc", {17'h0, bus.pc}, 32'd17);

        // JGT not taken with D=0x8000
        wait_fetch(15'd21, 30);
        chk("jn_d", {16'h0, bus.d_reg}, 32'h8000);
        repeat (3) tick();
        chk("jn_pc", {17'h0, bus.pc}, 32'd22);

        // M=D with ack withheld; reset in the second write wait cycle
        ack_delay = 100;
        repeat (3) tick();
        chk("rw_req1", {31'h0, bus.mem_req}, 32'h1);
        tick();
        chk("rw_req2", {31'h0, bus.mem_req}, 32'h1);
        chk("rw_addr", {17'h0, bus.mem_addr}, 32'd30);
        chk("rw_wdata", {16'h0, bus.mem_wdata}, 32'h8000);
        reset = 1'b1;
        tick();
        chk("rw_req_after", {31'h0, bus.mem_req}, 32'h0);
        chk("rw_pc", {17'h0, bus.pc}, 32'h0);
        chk("rw_a", {16'h0, bus.a_reg}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rw_rom_en", {31'h0, bus.rom_en}, 32'h1);
        tick();
        chk("rw_count", n_writes, 32'd1);
        chk("rw_ram", {16'h0, ram[30]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hack_cpu_ctrl
`default_nettype wire
